oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine sitting directly between cpu_2a03's bus outputs (addr, data_out, rw) and the system bus.
- A CPU write of page value P to $4014 stalls the CPU and copies 256 bytes from $PP00–$PPFF to the PPU OAM data port $2004.
- Cycle-accurate 513/514-cycle stall, aligned to the APU get/put parity.
- In idle, the block is a transparent pass-through.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per DMA; must be a power of two ≤256.

Ports:
- clock  in  1  system CPU clock (same clock as cpu_2a03)
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  16  address from cpu_2a03
- cpu_data_out  in  8  write data from cpu_2a03
- cpu_rw  in  1  cpu_2a03 direction, 1=read, 0=write
- bus_data_in  in  8  read data from system bus (also forwarded to CPU data_in externally)
- bus_addr  out  16  system address bus
- bus_data_out  out  8  system write data
- bus_rw  out  1  system direction, 1=read, 0=write
- cpu_halt  out  1  high = CPU must hold all state this cycle (gates cpu_2a03 clock enable)
- dma_active  out  1  high whenever state≠IDLE

Behaviour:
- Reset values:
  - State IDLE; parity=0; idx=0; page=0; buf=0.
  - cpu_halt=0, dma_active=0.
  - Bus outputs mirror the CPU inputs (combinational pass-through).
- Parity: a 1-bit toggle flips every clock. parity=0 is a "get" (read) cycle; parity=1 is a "put" (write) cycle.
- IDLE:
  - bus_* = cpu_*; cpu_halt=0.
  - If cpu_rw=0 and cpu_addr=TRIGGER_ADDR: latch page<=cpu_data_out, idx<=0, next state HALT. The trigger write itself passes through to the bus.
- HALT:
  - 1 cycle. cpu_halt=1; bus_addr=cpu_addr; bus_rw=1 (dummy read, no write).
  - Next state: READ if parity (next) = 0, else ALIGN.
- ALIGN:
  - 1 cycle. Same bus drive as HALT; cpu_halt=1.
  - Next state READ.
- READ:
  - bus_addr={page,idx}; bus_rw=1; cpu_halt=1.
  - buf<=bus_data_in.
  - Next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR; bus_data_out=buf; bus_rw=0; cpu_halt=1.
  - If idx==XFER_LEN-1, next state IDLE; otherwise idx<=idx+1 and next state READ.
- Total stall: 513 cycles (no ALIGN) or 514 cycles (with ALIGN). cpu_halt deasserts in the cycle after the final WRITE.
- idx is 8 bits and never wraps mid-transfer. page is constant for the whole transfer.
- Triggers while not IDLE are ignored; the CPU is halted, so they are unreachable in normal operation.
- Reset mid-transfer: next cycle state=IDLE, cpu_halt=0, no further OAM writes, idx cleared.
- A trigger in the same cycle as reset: reset wins.

Optional Feature:
- Macro: OAM_DMA_DMC_STEAL_EN.
- When defined:
  - Adds ports: dmc_req in 1, dmc_addr in 16, dmc_data out 8, dmc_ack out 1.
  - A pending dmc_req takes priority over a READ on a get cycle. That cycle drives bus_addr=dmc_addr, bus_rw=1, dmc_data<=bus_data_in, and pulses dmc_ack for 1 cycle.
  - The OAM sequence resumes at the next get cycle with idx unchanged, costing 2 extra cycles.
  - In IDLE, dmc_req halts the CPU for 1 HALT cycle plus the steal read.
- When undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Shared define file dma_values.v (alongside control_values.v) holds:
  - State encodings: DMA_STATE_IDLE/HALT/ALIGN/READ/WRITE, 3 bits.
  - Default TRIGGER_ADDR and OAM_DATA_ADDR.
- No sub-module: the parity toggle and idx counter stay inline.

Test Plan:
- Write $4014=$02 with parity at HALT exit = 0 → cpu_halt high for exactly 513 cycles; reads $0200..$02FF alternate with writes to $2004; written bytes equal a preloaded pattern.
- Same trigger offset by one clock → exactly one ALIGN cycle, 514-cycle stall, data identical.
- Page $FF → last read address $FFFF; idx does not wrap; returns to IDLE; a subsequent CPU read of $8000 passes through unchanged.
- Assert reset at the 100th WRITE → next cycle cpu_halt=0, state IDLE, no further bus_rw=0 to $2004.
- Idle pass-through: random CPU addr/data/rw sequences → bus_* equal cpu_* every cycle; writes to $4015/$4013 do not trigger.
- (OAM_DMA_DMC_STEAL_EN) dmc_req during transfer → one get cycle reads dmc_addr with a dmc_ack pulse; stall lengthens by 2 cycles; OAM byte order is intact.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared state encodings and default bus addresses for the sprite DMA engine.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_STATE_IDLE  = 3'd0,
    DMA_STATE_HALT  = 3'd1,
    DMA_STATE_ALIGN = 3'd2,
    DMA_STATE_READ  = 3'd3,
    DMA_STATE_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DEF_TRIGGER_ADDR  = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR halts the CPU and copies one page to OAM.
// Optional DMC sample stealing is enabled with `define OAM_DMA_DMC_STEAL_EN.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR  = DEF_TRIGGER_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_rw,
  output logic        cpu_halt,
  output logic        dma_active
`ifdef OAM_DMA_DMC_STEAL_EN
  ,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic [7:0]  dmc_data,
  output logic        dmc_ack
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic       parity;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] data_buf;
  logic       trigger;

  assign trigger = !cpu_rw && (cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_DMC_STEAL_EN
  // oam_run separates a real sprite transfer from a halt taken only for a DMC fetch.
  logic oam_run;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DMA_STATE_IDLE;
      parity   <= 1'b0;
      idx      <= 8'd0;
      page     <= 8'd0;
      data_buf <= 8'd0;
      oam_run  <= 1'b0;
      dmc_data <= 8'd0;
      dmc_ack  <= 1'b0;
    end else begin
      parity  <= ~parity;
      dmc_ack <= 1'b0;
      case (state)
        DMA_STATE_IDLE: begin
          if (trigger) begin
            page    <= cpu_data_out;
            idx     <= 8'd0;
            oam_run <= 1'b1;
            state   <= DMA_STATE_HALT;
          end else if (dmc_req) begin
            oam_run <= 1'b0;
            state   <= DMA_STATE_HALT;
          end
        end
        DMA_STATE_HALT:  state <= parity ? DMA_STATE_READ : DMA_STATE_ALIGN;
        DMA_STATE_ALIGN: state <= DMA_STATE_READ;
        DMA_STATE_READ: begin
          if (dmc_req) begin
            // Steal this get cycle; the put cycle after it becomes a dummy read.
            dmc_data <= bus_data_in;
            dmc_ack  <= 1'b1;
            state    <= oam_run ? DMA_STATE_ALIGN : DMA_STATE_IDLE;
          end else if (!oam_run) begin
            state <= DMA_STATE_IDLE;
          end else begin
            data_buf <= bus_data_in;
            state    <= DMA_STATE_WRITE;
          end
        end
        DMA_STATE_WRITE: begin
          if (idx == LAST_IDX) begin
            oam_run <= 1'b0;
            state   <= DMA_STATE_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= DMA_STATE_READ;
          end
        end
        default: state <= DMA_STATE_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DMA_STATE_IDLE;
      parity   <= 1'b0;
      idx      <= 8'd0;
      page     <= 8'd0;
      data_buf <= 8'd0;
    end else begin
      parity <= ~parity;
      case (state)
        DMA_STATE_IDLE: begin
          if (trigger) begin
            page  <= cpu_data_out;
            idx   <= 8'd0;
            state <= DMA_STATE_HALT;
          end
        end
        // Reads must land on get cycles (parity 0), so insert ALIGN when the next cycle is a put.
        DMA_STATE_HALT:  state <= parity ? DMA_STATE_READ : DMA_STATE_ALIGN;
        DMA_STATE_ALIGN: state <= DMA_STATE_READ;
        DMA_STATE_READ: begin
          data_buf <= bus_data_in;
          state    <= DMA_STATE_WRITE;
        end
        DMA_STATE_WRITE: begin
          if (idx == LAST_IDX) begin
            state <= DMA_STATE_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= DMA_STATE_READ;
          end
        end
        default: state <= DMA_STATE_IDLE;
      endcase
    end
  end
`endif

  always_comb begin
    bus_addr     = cpu_addr;
    bus_data_out = cpu_data_out;
    bus_rw       = cpu_rw;
    case (state)
      DMA_STATE_HALT, DMA_STATE_ALIGN: bus_rw = 1'b1;
      DMA_STATE_READ: begin
        bus_addr = {page, idx};
        bus_rw   = 1'b1;
`ifdef OAM_DMA_DMC_STEAL_EN
        if (dmc_req) bus_addr = dmc_addr;
`endif
      end
      DMA_STATE_WRITE: begin
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = data_buf;
        bus_rw       = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_halt   = (state != DMA_STATE_IDLE);
  assign dma_active = (state != DMA_STATE_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: idle pass-through table, aligned/unaligned transfers,
// last page, mid-transfer reset and reset-vs-trigger priority.
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rw;
  logic        cpu_halt;
  logic        dma_active;
`ifdef OAM_DMA_DMC_STEAL_EN
  logic        dmc_req  = 1'b0;
  logic [15:0] dmc_addr = 16'h0000;
  logic [7:0]  dmc_data;
  logic        dmc_ack;
`endif

  int applied     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  oam_dma dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_rw       (cpu_rw),
    .bus_data_in  (bus_data_in),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_rw       (bus_rw),
    .cpu_halt     (cpu_halt),
    .dma_active   (dma_active)
`ifdef OAM_DMA_DMC_STEAL_EN
    ,
    .dmc_req      (dmc_req),
    .dmc_addr     (dmc_addr),
    .dmc_data     (dmc_data),
    .dmc_ack      (dmc_ack)
`endif
  );

  // Memory image seen on the system bus.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  assign bus_data_in = pat(bus_addr);

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_rw;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    cpu_rw       = 1'b1;
    cpu_addr     = 16'h8000;
    cpu_data_out = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  // Trigger a DMA from the current cycle and follow it cycle by cycle.
  // pre = number of dummy cycles (HALT [+ALIGN]) before the first read.
  task automatic run_dma(input logic [7:0] page, input int pre, input int exp_stall,
                         input int reset_at_write);
    int stall, bad, writes, stray, k, i;
    logic [15:0] ea, last_read;
    logic [7:0]  ed;
    logic        erw;
    bit          did_reset;
    stall = 0; bad = 0; writes = 0; stray = 0; did_reset = 0;
    last_read = 16'h0000;
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = page;
    @(negedge clock);
    check("trigger_passthru", {cpu_halt, bus_rw, bus_addr, bus_data_out},
          {1'b0, 1'b0, 16'h4014, page});
    step();
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_out = 8'h00;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (!cpu_halt) break;
      stall++;
      ed = 8'h00;
      if (n < pre) begin
        ea = 16'h8000; erw = 1'b1;
      end else begin
        k = n - pre;
        i = k / 2;
        if (k % 2 == 0) begin
          ea = {page, 8'(i)}; erw = 1'b1;
        end else begin
          ea = 16'h2004; erw = 1'b0; ed = pat({page, 8'(i)});
        end
      end
      if (bus_addr !== ea || bus_rw !== erw || dma_active !== 1'b1 ||
          (!erw && bus_data_out !== ed)) begin
        bad++;
        if (bad == 1)
          $display("  first deviation at stall cycle %0d: addr %h rw %b data %h, expected addr %h rw %b data %h",
                   n, bus_addr, bus_rw, bus_data_out, ea, erw, ed);
      end
      if (erw && n >= pre) last_read = bus_addr;
      if (!bus_rw && bus_addr == 16'h2004) writes++;
      if (reset_at_write != 0 && !bus_rw && bus_addr == 16'h2004 && writes == reset_at_write) begin
        reset = 1'b1;
        did_reset = 1;
        break;
      end
    end
    check("seq_deviations", bad, 0);
    if (did_reset) begin
      @(negedge clock);
      reset = 1'b0;
      check("rst_mid_halt", cpu_halt, 1'b0);
      check("rst_mid_active", dma_active, 1'b0);
      for (int n = 0; n < 600; n++) begin
        @(negedge clock);
        if ((!bus_rw && bus_addr == 16'h2004) || cpu_halt) stray++;
      end
      check("rst_mid_stray", stray, 0);
      check("rst_mid_writes", writes, reset_at_write);
    end else begin
      check("stall_len", stall, exp_stall);
      check("oam_writes", writes, 256);
      check("last_read_addr", last_read, {page, 8'hFF});
      check("post_passthru", {cpu_halt, bus_rw, bus_addr}, {1'b0, 1'b1, 16'h8000});
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        rr;

    vecs[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 8'h0F, 1'b0, 16'h4015, 8'h0F, 1'b0, 1'b0};
    vecs[2] = '{16'h4013, 8'hFF, 1'b0, 16'h4013, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 8'hAA, 1'b0, 16'h0000, 8'hAA, 1'b0, 1'b0};
    vecs[5] = '{16'h2004, 8'h55, 1'b0, 16'h2004, 8'h55, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 8'h3C, 1'b1, 16'hFFFF, 8'h3C, 1'b1, 1'b0};
    vecs[7] = '{16'h4016, 8'h01, 1'b0, 16'h4016, 8'h01, 1'b0, 1'b0};

    do_reset();
    @(negedge clock);
    check("reset_state", {cpu_halt, dma_active, bus_rw, bus_addr}, {1'b0, 1'b0, 1'b1, 16'h8000});
    step();

    foreach (vecs[v]) begin
      cpu_addr = vecs[v].addr; cpu_data_out = vecs[v].data; cpu_rw = vecs[v].rw;
      @(negedge clock);
      check($sformatf("idle_vec%0d", v), {cpu_halt, bus_rw, bus_addr, bus_data_out},
            {vecs[v].exp_halt, vecs[v].exp_rw, vecs[v].exp_addr, vecs[v].exp_data});
      step();
    end
    cpu_addr = 16'h8000; cpu_rw = 1'b1;
    @(negedge clock);
    check("idle_no_trigger", cpu_halt, 1'b0);
    step();

    for (int r = 0; r < 32; r++) begin
      ra = 16'($urandom);
      rd = 8'($urandom);
      rr = 1'($urandom);
      if (ra == 16'h4014) ra = 16'h4015;
      cpu_addr = ra; cpu_data_out = rd; cpu_rw = rr;
      @(negedge clock);
      check("idle_random", {cpu_halt, bus_rw, bus_addr, bus_data_out}, {1'b0, rr, ra, rd});
      step();
    end

    // Trigger on a get cycle: no ALIGN.
    do_reset();
    run_dma(8'h02, 1, 513, 0);
    step();

    // Trigger one clock later: one ALIGN cycle.
    do_reset();
    step();
    run_dma(8'h02, 2, 514, 0);
    step();

    // Last page: final read at $FFFF, no wrap.
    do_reset();
    run_dma(8'hFF, 1, 513, 0);
    step();

    // Reset during the 100th OAM write.
    do_reset();
    run_dma(8'h02, 1, 0, 100);
    step();

    // Reset and trigger in the same cycle: reset wins.
    reset = 1'b1; cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h03;
    step();
    reset = 1'b0; cpu_addr = 16'h8000; cpu_rw = 1'b1;
    @(negedge clock);
    check("reset_beats_trigger", {cpu_halt, dma_active}, 2'b00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
